// File: rtl/dmem_access_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_seq_pkg
// Description : Shared definitions for the data-memory access sequencer.
//               - dmem_state_e : sequencer state encoding
//               - mem_req_s    : registered memory request {we, addr, wdata}
//               - byte_merge() : replace one little-endian byte lane of a word
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_seq_pkg;

    localparam int DMEM_WORD_W     = 32;
    // Widest word address a 32-bit byte address can carry.
    localparam int DMEM_MAX_ADDR_W = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } dmem_state_e;

    typedef struct packed {
        logic                       we;
        logic [DMEM_MAX_ADDR_W-1:0] addr;
        logic [DMEM_WORD_W-1:0]     wdata;
    } mem_req_s;

    // Lane 0 is bits 7:0 (little-endian).
    function automatic logic [DMEM_WORD_W-1:0] byte_merge(
        input logic [DMEM_WORD_W-1:0] word,
        input logic [7:0]             byte_val,
        input logic [1:0]             lane
    );
        logic [DMEM_WORD_W-1:0] merged;
        merged = word;
        merged[{lane, 3'b000} +: 8] = byte_val;
        return merged;
    endfunction

endpackage : dmem_access_seq_pkg
`default_nettype wire

// File: rtl/dmem_access_seq_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_lane
// Description : Combinational byte-lane helper for sub-word memory ops.
//               merged_o  : word_i with lane lane_i replaced by byte_i (SB)
//               extract_o : lane lane_i of word_i, zero-extended (LBU)
// Ports       : word_i[31:0], byte_i[7:0], lane_i[1:0] -> merged_o, extract_o
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_lane
    import dmem_access_seq_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o,
    output logic [31:0] extract_o
);

    assign merged_o  = byte_merge(word_i, byte_i, lane_i);
    assign extract_o = {24'h00_0000, word_i[{lane_i, 3'b000} +: 8]};

endmodule : dmem_byte_lane
`default_nettype wire

// File: rtl/dmem_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_seq
// Description : Sequences LW / LBU / SW / SB onto a word-wide, variable-latency
//               data memory using a req/ack handshake. SB is a read-modify-
//               write, LBU a word read plus byte extraction. stall_o holds the
//               core while an access is in flight.
// Ports       : clk, n_reset (async, active low)
//               op_valid_i/op_ready_o, is_load/store/byte_op_i, addr_i,
//               store_data_i   - decoded op from execute
//               rd_data_o/rd_valid_o - load result (one-cycle valid pulse)
//               stall_o        - pipeline hold
//               mem_req_o/we_o/addr_o/wdata_o, mem_ack_i/rdata_i - memory
//               mem_err_o      - ack timeout pulse (DMEM_TIMEOUT_EN only)
// Options     : `define DMEM_TIMEOUT_EN adds the ack-wait timeout counter and
//               the mem_err_o port; otherwise the block waits forever.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_seq
    import dmem_access_seq_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_byte_op_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic              mem_err_o
`endif
);

    if (DATA_W != 32) begin : g_data_w_chk
        $error("dmem_access_seq: DATA_W must be 32");
    end
    if (ADDR_W > DMEM_MAX_ADDR_W) begin : g_addr_w_chk
        $error("dmem_access_seq: ADDR_W must not exceed 30");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    dmem_state_e state_q, state_d;
    mem_req_s    mem_q, mem_d;
    logic        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;       // word captured from memory
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        is_load_q, is_load_d;
    logic        is_byte_q, is_byte_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  sbyte_q, sbyte_d;       // SB source byte

    logic        w_accept;
    logic        w_tmo_hit;
    logic [31:0] w_merged;
    logic [31:0] w_extract;

    assign w_accept = (state_q == ST_IDLE) && op_valid_i &&
                      (is_load_op_i || is_store_op_i);

    dmem_byte_lane u_byte_lane (
        .word_i    (rdata_q),
        .byte_i    (sbyte_q),
        .lane_i    (lane_q),
        .merged_o  (w_merged),
        .extract_o (w_extract)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A load wins when both op flags are set.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    // Loads and SB both need the current word first.
                    state_d = (is_load_op_i || is_byte_op_i) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                if (mem_ack_i) begin
                    state_d = is_load_q ? ST_RESP : ST_MERGE;
                end else if (w_tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MERGE: state_d = ST_WR;
            ST_WR: begin
                if (mem_ack_i || w_tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs / datapath next values. Request fields are registered
    // from the next state, so they only change on entry to RD or WR and
    // stay frozen while req is high.
    // ------------------------------------------------------------------
    always_comb begin
        mem_d      = mem_q;
        rdata_d    = rdata_q;
        rd_data_d  = rd_data_q;
        is_load_d  = is_load_q;
        is_byte_d  = is_byte_q;
        lane_d     = lane_q;
        sbyte_d    = sbyte_q;

        if (w_accept) begin
            is_load_d  = is_load_op_i;
            is_byte_d  = is_byte_op_i;
            lane_d     = addr_i[1:0];
            sbyte_d    = store_data_i[7:0];
            // Upper address bits beyond the memory window are dropped.
            mem_d.addr = DMEM_MAX_ADDR_W'(addr_i[ADDR_W+1:2]);
            if (!is_load_op_i && !is_byte_op_i) begin
                mem_d.wdata = store_data_i;
            end
        end

        if ((state_q == ST_RD) && mem_ack_i) begin
            rdata_d = mem_rdata_i;
        end

        if (state_q == ST_MERGE) begin
            mem_d.wdata = w_merged;
        end

        mem_d.we   = (state_d == ST_WR);
        req_d      = (state_d == ST_RD) || (state_d == ST_WR);

        // The result register is loaded from RESP, so the valid pulse
        // appears the cycle after RESP.
        rd_valid_d = (state_q == ST_RESP);
        if (state_q == ST_RESP) begin
            rd_data_d = is_byte_q ? w_extract : rdata_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mem_q      <= '0;
            req_q      <= 1'b0;
            rdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            is_load_q  <= 1'b0;
            is_byte_q  <= 1'b0;
            lane_q     <= 2'b00;
            sbyte_q    <= 8'h00;
        end else begin
            mem_q      <= mem_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            is_load_q  <= is_load_d;
            is_byte_q  <= is_byte_d;
            lane_q     <= lane_d;
            sbyte_q    <= sbyte_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional ack-wait timeout
    // ------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    // Counts un-acked request cycles; an ack on the limit cycle wins.
    always_comb begin
        tmo_cnt_d = '0;
        w_tmo_hit = 1'b0;
        if (((state_q == ST_RD) || (state_q == ST_WR)) && !mem_ack_i) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_tmo_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
        err_d = w_tmo_hit;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign mem_err_o = err_q;
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign op_ready_o  = (state_q == ST_IDLE);
    assign stall_o     = (state_q != ST_IDLE);
    assign mem_req_o   = req_q;
    assign mem_we_o    = mem_q.we;
    assign mem_addr_o  = mem_q.addr[ADDR_W-1:0];
    assign mem_wdata_o = mem_q.wdata;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;

    // A decoded op must not be both a load and a store.
    a_ld_st_excl: assert property (@(posedge clk) disable iff (!n_reset)
        !(w_accept && is_load_op_i && is_store_op_i))
        else $warning("dmem_access_seq: op flagged as both load and store");

endmodule : dmem_access_seq
`default_nettype wire
